// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver feeding a small first-word-fall-through receive FIFO.
//   The serial line is synchronised, a falling edge starts a frame, the start
//   bit is re-checked at mid-bit, eight data bits are sampled LSB first at
//   bit centres, and the stop bit decides between pushing the byte and
//   raising the sticky framing-error flag.
//
// Parameters
//   clk_freq        system clock frequency in Hz
//   uart_baud_rate  line rate; divisor = clk_freq / uart_baud_rate (>= 4)
//   fifo_depth      FIFO entries, power of two, >= 2
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   uart_rxd   in   serial line, idle high, asynchronous to clk
//   rx_ack     in   pop the head entry (ignored when empty)
//   err_clr    in   clear frame_err and overflow (a same-cycle set wins)
//   rx_data    out  head-of-FIFO byte, meaningful while rx_valid
//   rx_valid   out  FIFO not empty
//   rx_count   out  number of stored bytes, 0..fifo_depth
//   busy       out  receiver not idle
//   frame_err  out  sticky: stop bit sampled low
//   overflow   out  sticky: a good byte was dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 115200,
    parameter int fifo_depth     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rxd,
    input  logic                          rx_ack,
    input  logic                          err_clr,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(fifo_depth):0]   rx_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int DIVISOR = clk_freq / uart_baud_rate;
    localparam int CNT_W   = $clog2(DIVISOR);
    localparam int AW      = $clog2(fifo_depth);
    localparam int CW      = AW + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(fifo_depth);

    generate
        if (DIVISOR < 4) begin : g_bad_divisor
            $error("uart_rx_fifo: clk_freq / uart_baud_rate must be >= 4");
        end
        if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
            $error("uart_rx_fifo: fifo_depth must be a power of two >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detector
    // ------------------------------------------------------------------
    logic       sync1_q, sync2_q, prev_q;
    logic [1:0] arm_q;
    logic       start_edge;

    // The synchroniser flops come out of reset high, which would fake a
    // high->low transition if the pin is already low at release. arm_q
    // holds prev_q at 0 until sync2_q carries a genuine pin value, so only
    // a real high->low transition after reset can start a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b0;
            arm_q   <= 2'b00;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            arm_q   <= {arm_q[0], 1'b1};
            prev_q  <= arm_q[1] & sync2_q;
        end
    end

    assign start_edge = ~sync2_q & prev_q;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bitidx_q;
    logic [7:0]       shreg_q;
    logic             busy_q;

    logic             cnt_last, cnt_half;
    logic             stop_hit, push_req, frame_set;

    assign cnt_last = (cnt_q == CNT_LAST);
    assign cnt_half = (cnt_q == CNT_HALF);

    // Stop-bit decision is decoded combinationally so the push and the
    // flag update land on the stop-sample edge itself.
    always_comb begin
        stop_hit  = (state_q == STOP) && cnt_last;
        push_req  = stop_hit & sync2_q;
        frame_set = stop_hit & ~sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitidx_q <= 3'd0;
            shreg_q  <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_half) begin
                        cnt_q <= '0;
                        if (!sync2_q) begin
                            state_q  <= DATA;
                            bitidx_q <= 3'd0;
                        end else begin
                            // line back high at mid-start: glitch, no flag
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt_q             <= '0;
                        shreg_q[bitidx_q] <= sync2_q;
                        if (bitidx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bitidx_q <= bitidx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO and sticky flags
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [fifo_depth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, pop, push, ovf_set;

    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        pop     = rx_ack & ~empty;
        // a pop in the same cycle frees the slot the full FIFO needs
        push    = push_req & (~full | pop);
        ovf_set = push_req & full & ~pop;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // set has priority over clear
        frame_err_d = frame_set | (frame_err_q & ~err_clr);
        overflow_d  = ovf_set   | (overflow_q  & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < fifo_depth; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shreg_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rx_data   = mem_q[rd_ptr_q];
    assign rx_valid  = ~empty;
    assign rx_count  = count_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo (divisor 16, 4-entry FIFO).
//   A queue-based reference model tracks the bytes that should be stored
//   and the two sticky flags; directed scenarios are followed by a run of
//   random frames, pops and flag clears.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 16000000;
    localparam int BAUD     = 1000000;
    localparam int DEPTH    = 4;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic       rx_ack;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       busy;
    logic       frame_err;
    logic       overflow;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .clk_freq       (CLK_FREQ),
        .uart_baud_rate (BAUD),
        .fifo_depth     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .rx_ack    (rx_ack),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_fe  = 1'b0;
    logic       exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "/valid"}, 32'(rx_valid), 32'(exp_q.size() > 0));
        chk({tag, "/count"}, 32'(rx_count), 32'(exp_q.size()));
        if (exp_q.size() > 0) chk({tag, "/data"}, 32'(rx_data), 32'(exp_q[0]));
        chk({tag, "/frame_err"}, 32'(frame_err), 32'(exp_fe));
        chk({tag, "/overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, "/busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_pop(input string tag);
        if (exp_q.size() > 0) chk({tag, "/head"}, 32'(rx_data), 32'(exp_q[0]));
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk({tag, "/count_after_pop"}, 32'(rx_count), 32'(exp_q.size()));
    endtask

    task automatic do_clr(input string tag);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        exp_fe  = 1'b0;
        exp_ovf = 1'b0;
        chk({tag, "/fe_clr"}, 32'(frame_err), 32'd0);
        chk({tag, "/ovf_clr"}, 32'(overflow), 32'd0);
    endtask

    // One 8N1 frame starting right after a rising edge P0. With the 2-flop
    // synchroniser the start edge is seen at P0+3, so the stop bit is
    // sampled on edge P0+155 and the result is visible just after it.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic stop_v,
                              input logic ack_at_stop, input int hold_low);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int k = 0; k < 9; k++) begin
            uart_rxd = bits[k];
            tick(BIT_CYC);
        end
        uart_rxd = stop_v;
        tick(10);
        chk({tag, "/pre_stop_count"}, 32'(rx_count), 32'(exp_q.size()));
        chk({tag, "/pre_stop_busy"}, 32'(busy), 32'd1);
        if (ack_at_stop) begin
            if (exp_q.size() > 0) chk({tag, "/pre_stop_head"}, 32'(rx_data), 32'(exp_q[0]));
            rx_ack = 1'b1;
        end
        tick(1);
        rx_ack = 1'b0;
        if (ack_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (stop_v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovf = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
        check_idle({tag, "/stop"});
        tick(5);
        if (!stop_v) begin
            // line stays low: no new frame may begin until it goes high again
            tick(hold_low);
            chk({tag, "/break_busy"}, 32'(busy), 32'd0);
            chk({tag, "/break_count"}, 32'(rx_count), 32'(exp_q.size()));
            uart_rxd = 1'b1;
            tick(BIT_CYC);
        end
        uart_rxd = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        rst      = 1'b1;
        uart_rxd = 1'b1;
        rx_ack   = 1'b0;
        err_clr  = 1'b0;
        tick(3);

        // reset values
        chk("rst/valid", 32'(rx_valid), 32'd0);
        chk("rst/count", 32'(rx_count), 32'd0);
        chk("rst/data", 32'(rx_data), 32'h00);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/frame_err", 32'(frame_err), 32'd0);
        chk("rst/overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick(6);

        // single byte, exact push timing checked inside send_frame
        send_frame("single", 8'hA5, 1'b1, 1'b0, 0);
        tick(4);
        check_idle("single/after");
        do_pop("single");
        do_pop("pop_empty");

        // glitch rejection
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        tick(2);
        chk("glitch/busy_mid", 32'(busy), 32'd1);
        tick(14);
        check_idle("glitch");

        // framing error with line held low, then a good byte
        send_frame("frame", 8'h3C, 1'b0, 1'b0, 40);
        send_frame("after_break", 8'h11, 1'b1, 1'b0, 0);
        do_clr("frame_clr");
        check_idle("frame_clr");
        do_pop("after_break");

        // overflow: five bytes, no pops
        for (int i = 1; i <= 5; i++) begin
            send_frame("ovf", 8'(i), 1'b1, 1'b0, 0);
        end
        chk("ovf/count", 32'(rx_count), 32'd4);
        chk("ovf/flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf/order", 32'(rx_data), 32'(i));
            do_pop("ovf");
        end
        do_clr("ovf_clr");

        // full FIFO with a pop on the stop-sample edge
        for (int i = 0; i < 4; i++) begin
            send_frame("fill", 8'($urandom_range(0, 255)), 1'b1, 1'b0, 0);
        end
        send_frame("full_pop", 8'h77, 1'b1, 1'b1, 0);
        chk("full_pop/overflow", 32'(overflow), 32'd0);
        chk("full_pop/count", 32'(rx_count), 32'd4);
        for (int i = 0; i < 3; i++) do_pop("full_pop_drain");
        chk("full_pop/last", 32'(rx_data), 32'h77);
        do_pop("full_pop_drain");

        // random frames, pops and clears
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame("rand", b, ($urandom_range(0, 7) != 0), 1'b0,
                       int'($urandom_range(0, 30)));
            tick(int'($urandom_range(0, 20)));
            for (int p = int'($urandom_range(0, 1)); p > 0; p--) do_pop("rand");
            if ($urandom_range(0, 3) == 0) do_clr("rand");
            check_idle("rand/idle");
        end

        // reset in the middle of 8'hF0, with something stored first
        send_frame("pre_rst", 8'h99, 1'b1, 1'b0, 0);
        uart_rxd = 1'b0;
        tick(BIT_CYC);
        for (int k = 0; k < 3; k++) tick(BIT_CYC);
        tick(6);
        rst = 1'b1;
        #2;
        exp_q.delete();
        exp_fe  = 1'b0;
        exp_ovf = 1'b0;
        chk("midrst/data", 32'(rx_data), 32'h00);
        check_idle("midrst");
        uart_rxd = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(6);
        send_frame("post_rst", 8'h5A, 1'b1, 1'b0, 0);
        chk("post_rst/data", 32'(rx_data), 32'h5A);
        do_pop("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
